// File: rtl/switch_debounce_fsm_pkg.sv
// rtl/switch_debounce_fsm_pkg.sv - debounce FSM state type, default timing constants, sample helper
package switch_debounce_pkg;

   typedef enum logic [1:0] {
      STABLE_LO = 2'b00,
      WAIT_HI   = 2'b01,
      STABLE_HI = 2'b10,
      WAIT_LO   = 2'b11
   } state_t;

   localparam int DEBOUNCE_CYCLES_DEF = 4;
   localparam int LONG_CYCLES_DEF     = 10;

   // True when the sample points away from the level the state is holding or heading from.
   function automatic logic sample_moves(input state_t s, input logic d);
      return (s == STABLE_LO || s == WAIT_HI) ? d : ~d;
   endfunction

endpackage

// File: rtl/switch_debounce_fsm_if.sv
// rtl/switch_debounce_fsm_if.sv - switch level in, debounced level and strobes out
interface switch_debounce_fsm_if;
   logic d_in;
   logic o_level;
   logic o_rise;
   logic o_fall;
   logic o_long;

   modport master (output d_in, input o_level, input o_rise, input o_fall, input o_long);
   modport slave  (input d_in, output o_level, output o_rise, output o_fall, output o_long);
endinterface

// File: rtl/switch_debounce_fsm_debounce_counter.sv
// rtl/switch_debounce_fsm_debounce_counter.sv - clear/increment counter with terminal-count flag
module debounce_counter #(
   parameter int               WIDTH    = 20,
   parameter logic [WIDTH-1:0] TERMINAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] cnt,
   output logic             tc
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tc = (cnt == TERMINAL);

endmodule

// File: rtl/switch_debounce_fsm.sv
// rtl/switch_debounce_fsm.sv - switch debouncer with press/release strobes
// Optional long-press strobe when SWITCH_DEBOUNCE_LONG_PRESS_EN is defined.
module switch_debounce_fsm
   import switch_debounce_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int   CNT_WIDTH       = 20,
   parameter logic RST_LEVEL       = 1'b0,
   parameter int   LONG_CYCLES     = LONG_CYCLES_DEF,
   parameter int   LONG_WIDTH      = 24
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   switch_debounce_fsm_if.slave sw
);

   localparam logic [CNT_WIDTH-1:0] DB_TERM = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   generate
      if (DEBOUNCE_CYCLES < 2 || (longint'(1) << CNT_WIDTH) <= longint'(DEBOUNCE_CYCLES) ||
          LONG_CYCLES < 2 || (longint'(1) << LONG_WIDTH) <= longint'(LONG_CYCLES)) begin : g_bad_params
         $error("switch_debounce_fsm: illegal parameter combination");
      end
   endgenerate

   state_t               state;
   logic                 level_q;
   logic                 rise_q;
   logic                 fall_q;
   logic                 long_q;
   logic                 moving;
   logic                 db_tc;
   logic [CNT_WIDTH-1:0] db_cnt;

   // Counter runs only while consecutive samples disagree with the held level.
   assign moving = sample_moves(state, sw.d_in);

   debounce_counter #(
      .WIDTH    (CNT_WIDTH),
      .TERMINAL (DB_TERM)
   ) u_db_cnt (
      .clk (i_clk),
      .rst (i_rst),
      .clr (~moving | db_tc),
      .inc (moving & ~db_tc),
      .cnt (db_cnt),
      .tc  (db_tc)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state   <= RST_LEVEL ? STABLE_HI : STABLE_LO;
         level_q <= RST_LEVEL;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         case (state)
            STABLE_LO: if (sw.d_in) state <= WAIT_HI;
            WAIT_HI: begin
               if (!sw.d_in) begin
                  state <= STABLE_LO;
               end else if (db_tc) begin
                  state   <= STABLE_HI;
                  level_q <= 1'b1;
                  rise_q  <= 1'b1;
               end
            end
            STABLE_HI: if (!sw.d_in) state <= WAIT_LO;
            WAIT_LO: begin
               if (sw.d_in) begin
                  state <= STABLE_HI;
               end else if (db_tc) begin
                  state   <= STABLE_LO;
                  level_q <= 1'b0;
                  fall_q  <= 1'b1;
               end
            end
            default: state <= STABLE_LO;
         endcase
      end
   end

`ifdef SWITCH_DEBOUNCE_LONG_PRESS_EN
   localparam logic [LONG_WIDTH-1:0] LONG_TERM = LONG_WIDTH'(LONG_CYCLES - 1);
   localparam logic [LONG_WIDTH-1:0] LONG_PRE  = LONG_WIDTH'(LONG_CYCLES - 2);

   logic                  fall_commit;
   logic                  long_inc;
   logic                  long_tc;
   logic [LONG_WIDTH-1:0] long_cnt;

   // A release committing this edge wins over a long-press firing on the same edge.
   assign fall_commit = (state == WAIT_LO) & moving & db_tc;
   assign long_inc    = level_q & ~long_tc & ~fall_commit;

   debounce_counter #(
      .WIDTH    (LONG_WIDTH),
      .TERMINAL (LONG_TERM)
   ) u_long_cnt (
      .clk (i_clk),
      .rst (i_rst),
      .clr (~level_q | fall_commit),
      .inc (long_inc),
      .cnt (long_cnt),
      .tc  (long_tc)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         long_q <= 1'b0;
      end else begin
         long_q <= long_inc & (long_cnt == LONG_PRE);
      end
   end
`else
   assign long_q = 1'b0;
`endif

   assign sw.o_level = level_q;
   assign sw.o_rise  = rise_q;
   assign sw.o_fall  = fall_q;
   assign sw.o_long  = long_q;

endmodule

// File: tb/tb_switch_debounce_fsm.sv
// tb/tb_switch_debounce_fsm.sv - scoreboard bench for switch_debounce_fsm against a run-length model
module tb_switch_debounce_fsm;

   localparam int DB = 4;
   localparam int LC = 10;

   typedef struct {
      int         cyc;
      logic [3:0] outs;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   exp_t q[$];

   logic m_level;
   int   m_run;
   int   m_since;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   switch_debounce_fsm_if sw();

   switch_debounce_fsm #(
      .DEBOUNCE_CYCLES (DB),
      .CNT_WIDTH       (20),
      .RST_LEVEL       (1'b0),
      .LONG_CYCLES     (LC),
      .LONG_WIDTH      (24)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .sw    (sw.slave)
   );

   function automatic logic [3:0] outs();
      return {sw.o_level, sw.o_rise, sw.o_fall, sw.o_long};
   endfunction

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got {level,rise,fall,long}=%b expected %b", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_level = 1'b0;
      m_run   = 0;
      m_since = -1;
   endtask

   // Model: a change commits after DB consecutive samples differing from the level;
   // o_long fires when the level has been high for LC-1 edges since the rise.
   task automatic step(input logic d);
      exp_t e;
      logic r, f, l;
      bit   committed;
      r = 1'b0; f = 1'b0; l = 1'b0; committed = 0;
      sw.d_in = d;
      if (d != m_level) begin
         m_run++;
         if (m_run == DB) begin
            m_level   = d;
            m_run     = 0;
            committed = 1;
            r = d;
            f = ~d;
            m_since = d ? 0 : -1;
         end
      end else begin
         m_run = 0;
      end
      if (!committed && m_level && m_since >= 0) begin
         m_since++;
         if (m_since == LC - 1) l = 1'b1;
      end
`ifndef SWITCH_DEBOUNCE_LONG_PRESS_EN
      l = 1'b0;
`endif
      e.cyc  = cyc + 1;
      e.outs = {m_level, r, f, l};
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input logic d, input int n);
      for (int i = 0; i < n; i++) step(d);
   endtask

   task automatic reset_pulse(input string name);
      #5 rst = 1'b1;
      #1 check(name, outs(), 4'b0000);
      #1 rst = 1'b0;
      model_reset();
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            check(e.cyc == cyc ? "outputs" : "late_expectation", outs(), e.outs);
         end
      end
   end

   initial begin : stimulus
      sw.d_in = 1'b1;
      rst = 1'b1;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1 check("reset_hold", outs(), 4'b0000);
      end
      #1 rst = 1'b0;

      steps(1'b1, 4);
      steps(1'b1, 15);
      steps(1'b0, 3);
      steps(1'b1, 2);
      steps(1'b0, 6);

      steps(1'b1, 9);
      steps(1'b0, 6);

      steps(1'b1, 3); step(1'b0); steps(1'b1, 4); steps(1'b1, 2);

      steps(1'b0, 2);
      reset_pulse("reset_in_wait_lo");
      steps(1'b0, 3);
      steps(1'b1, 2);
      reset_pulse("reset_in_wait_hi");
      steps(1'b1, 4);
      steps(1'b1, 2);

      for (int b = 0; b < 60; b++) begin
         steps(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? $urandom_range(8, 16)
                                                                        : $urandom_range(1, 6));
      end

      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d pending expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
